// File: rtl/dijkstra_controller.sv
// Dijkstra sequencing controller: drives the distance queue, pops the
// minimum unvisited node, walks its edge list and relaxes each neighbour.
module dijkstra_controller #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic [INDEX_WIDTH-1:0] target,
  output logic                   busy,
  output logic                   done,
  output logic [VALUE_WIDTH-1:0] target_dist,
  output logic                   pq_reset,
  output logic                   pq_set_en,
  output logic [INDEX_WIDTH-1:0] pq_index,
  output logic [VALUE_WIDTH-1:0] pq_write_value,
  input  logic [VALUE_WIDTH-1:0] pq_read_value,
  input  logic [INDEX_WIDTH-1:0] pq_min_index,
  input  logic [VALUE_WIDTH-1:0] pq_min_value,
  input  logic                   pq_min_ready,
  output logic [MAX_NODES-1:0]   visited_vector,
  output logic                   visit_vector_true,
  output logic                   edge_req,
  output logic [INDEX_WIDTH-1:0] edge_node,
  output logic [INDEX_WIDTH:0]   edge_ord,
  input  logic                   edge_ack,
  input  logic                   edge_present,
  input  logic [INDEX_WIDTH-1:0] edge_dst,
  input  logic [VALUE_WIDTH-1:0] edge_weight
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_SETTLE, S_WAIT_MIN, S_FETCH,
    S_READ, S_RELAX, S_FINISH, S_DONE
  } state_t;

  localparam logic [VALUE_WIDTH-1:0] INF   = '1;
  localparam logic [INDEX_WIDTH:0]   K_CAP = (INDEX_WIDTH+1)'(MAX_NODES);

  state_t r_state, w_next;

  logic [INDEX_WIDTH-1:0] r_source, r_target, r_u, r_dst;
  logic [VALUE_WIDTH-1:0] r_du, r_w, r_dv, r_target_dist;
  logic [INDEX_WIDTH:0]   r_k;
  logic [MAX_NODES-1:0]   r_visited;
  logic                   r_visit_pulse;

  logic [VALUE_WIDTH:0]   w_sum;
  logic [VALUE_WIDTH-1:0] w_sum_sat;
  logic                   w_relax_wr;
  logic                   w_terminate;

  // Saturating relaxation sum and write decision
  always_comb begin
    w_sum      = {1'b0, r_du} + {1'b0, r_w};
    w_sum_sat  = w_sum[VALUE_WIDTH] ? INF : w_sum[VALUE_WIDTH-1:0];
    w_relax_wr = (r_state == S_RELAX) && !r_visited[r_dst] && (w_sum_sat < r_dv);
    w_terminate = (pq_min_value == INF) || (pq_min_index == r_target);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and queue/edge port drive
  always_comb begin
    w_next         = r_state;
    busy           = (r_state != S_IDLE);
    done           = 1'b0;
    pq_reset       = 1'b0;
    pq_set_en      = 1'b0;
    pq_index       = '0;
    pq_write_value = '0;
    edge_req       = 1'b0;
    edge_node      = '0;
    edge_ord       = '0;
    case (r_state)
      S_IDLE:     if (start) w_next = S_INIT;
      S_INIT: begin
        pq_reset = 1'b1;
        pq_index = r_source;
        w_next   = S_SETTLE;
      end
      S_SETTLE:   w_next = S_WAIT_MIN;
      S_WAIT_MIN: if (pq_min_ready) w_next = w_terminate ? S_FINISH : S_FETCH;
      S_FETCH: begin
        edge_req  = 1'b1;
        edge_node = r_u;
        edge_ord  = r_k;
        if (edge_ack) w_next = edge_present ? S_READ : S_SETTLE;
      end
      S_READ: begin
        pq_index = r_dst;
        w_next   = S_RELAX;
      end
      S_RELAX: begin
        pq_index = r_dst;
        if (w_relax_wr) begin
          pq_set_en      = 1'b1;
          pq_write_value = w_sum_sat;
        end
        w_next = (r_k == K_CAP) ? S_SETTLE : S_FETCH;
      end
      S_FINISH: begin
        pq_index = r_target;
        w_next   = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // Datapath registers: request latch, popped node, edge, visited set, result
  always_ff @(posedge clock) begin
    if (reset) begin
      r_source      <= '0;
      r_target      <= '0;
      r_u           <= '0;
      r_du          <= '0;
      r_dst         <= '0;
      r_w           <= '0;
      r_dv          <= '0;
      r_k           <= '0;
      r_visited     <= '0;
      r_visit_pulse <= 1'b0;
      r_target_dist <= '0;
    end else begin
      r_visit_pulse <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_source <= source;
          r_target <= target;
        end
        S_INIT: r_visited <= '0;
        S_WAIT_MIN: if (pq_min_ready) begin
          r_u  <= pq_min_index;
          r_du <= pq_min_value;
          if (!w_terminate) begin
            r_visited[pq_min_index] <= 1'b1;
            r_visit_pulse           <= 1'b1;
            r_k                     <= '0;
          end
        end
        S_FETCH: if (edge_ack && edge_present) begin
          r_dst <= edge_dst;
          r_w   <= edge_weight;
        end
        S_READ:   r_dv <= pq_read_value;
        S_RELAX:  r_k <= r_k + 1'b1;
        S_FINISH: r_target_dist <= pq_read_value;
        default: ;
      endcase
    end
  end

  assign visited_vector    = r_visited;
  assign visit_vector_true = r_visit_pulse;
  assign target_dist       = r_target_dist;

endmodule

// File: tb/tb_dijkstra_controller.sv
// Bench for dijkstra_controller: behavioural queue/heap and edge memory,
// reference shortest-path model, directed and randomized runs.
module tb_dijkstra_controller;
  localparam int N   = 16;
  localparam int IW  = 4;
  localparam int VW  = 16;
  localparam int INF = 32'h0000FFFF;

  logic clock = 1'b0;
  logic reset, start;
  logic [IW-1:0] source, target;
  logic busy, done;
  logic [VW-1:0] target_dist;
  logic pq_reset, pq_set_en;
  logic [IW-1:0] pq_index;
  logic [VW-1:0] pq_write_value, pq_read_value;
  logic [IW-1:0] pq_min_index;
  logic [VW-1:0] pq_min_value;
  logic pq_min_ready;
  logic [N-1:0] visited_vector;
  logic visit_vector_true, edge_req;
  logic [IW-1:0] edge_node;
  logic [IW:0] edge_ord;
  logic edge_ack, edge_present;
  logic [IW-1:0] edge_dst;
  logic [VW-1:0] edge_weight;

  dijkstra_controller #(.MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock(clock), .reset(reset), .start(start), .source(source), .target(target),
    .busy(busy), .done(done), .target_dist(target_dist),
    .pq_reset(pq_reset), .pq_set_en(pq_set_en), .pq_index(pq_index),
    .pq_write_value(pq_write_value), .pq_read_value(pq_read_value),
    .pq_min_index(pq_min_index), .pq_min_value(pq_min_value), .pq_min_ready(pq_min_ready),
    .visited_vector(visited_vector), .visit_vector_true(visit_vector_true),
    .edge_req(edge_req), .edge_node(edge_node), .edge_ord(edge_ord),
    .edge_ack(edge_ack), .edge_present(edge_present), .edge_dst(edge_dst),
    .edge_weight(edge_weight)
  );

  always #5 clock = ~clock;

  // Graph storage (edge memory contents)
  int          g_cnt [N];
  logic [IW-1:0] g_dst [N][N+1];
  logic [VW-1:0] g_w   [N][N+1];

  // Queue contents and environment randomness
  logic [VW-1:0] q_dist [N] = '{default: 16'hFFFF};
  logic r_eok = 1'b1, r_mrdy = 1'b1;
  logic [IW+VW-1:0] wlog [$];
  int n_done = 0, n_vpulse = 0, n_ereq = 0;
  int n_pass = 0, n_total = 0;

  always @(negedge clock) begin
    r_eok  <= ($urandom_range(0, 3) != 0);
    r_mrdy <= ($urandom_range(0, 2) != 0);
  end

  // Edge memory response
  always_comb begin
    edge_ack     = edge_req && r_eok;
    edge_present = 1'b0;
    edge_dst     = '0;
    edge_weight  = '0;
    if (int'(edge_ord) < g_cnt[edge_node]) begin
      edge_present = 1'b1;
      edge_dst     = g_dst[edge_node][edge_ord];
      edge_weight  = g_w[edge_node][edge_ord];
    end
  end

  // Queue read port and heap minimum over unvisited nodes (lowest index on ties)
  always_comb begin
    int best;
    best          = 32'h10000;
    pq_read_value = q_dist[pq_index];
    pq_min_index  = '0;
    pq_min_value  = 16'hFFFF;
    pq_min_ready  = r_mrdy;
    for (int i = 0; i < N; i++) begin
      if (!visited_vector[i] && int'(q_dist[i]) < best) begin
        best         = int'(q_dist[i]);
        pq_min_index = IW'(i);
        pq_min_value = q_dist[i];
      end
    end
  end

  always @(posedge clock) begin
    if (pq_reset) begin
      for (int i = 0; i < N; i++) q_dist[i] <= 16'hFFFF;
      q_dist[pq_index] <= '0;
    end else if (pq_set_en) begin
      q_dist[pq_index] <= pq_write_value;
      wlog.push_back({pq_index, pq_write_value});
    end
  end

  always @(posedge clock) begin
    if (done)              n_done   <= n_done + 1;
    if (visit_vector_true) n_vpulse <= n_vpulse + 1;
    if (edge_req)          n_ereq   <= n_ereq + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: textbook Dijkstra with saturating sums
  function automatic void ref_dij(input int src, input int tgt,
                                  output int td, output logic [N-1:0] vis);
    int d[N];
    bit v[N];
    int u, best, s, t;
    for (int i = 0; i < N; i++) begin d[i] = INF; v[i] = 0; end
    d[src] = 0;
    vis = '0;
    td = INF;
    for (int it = 0; it <= N; it++) begin
      best = INF + 1;
      u = 0;
      for (int i = 0; i < N; i++)
        if (!v[i] && d[i] < best) begin best = d[i]; u = i; end
      if (d[u] == INF || u == tgt) begin td = d[tgt]; break; end
      v[u] = 1;
      vis[u] = 1'b1;
      for (int j = 0; j < g_cnt[u]; j++) begin
        t = int'(g_dst[u][j]);
        if (!v[t]) begin
          s = d[u] + int'(g_w[u][j]);
          if (s > INF) s = INF;
          if (s < d[t]) d[t] = s;
        end
      end
    end
  endfunction

  task automatic clear_graph();
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
  endtask

  task automatic add_edge(input int s, input int d, input int w);
    g_dst[s][g_cnt[s]] = IW'(d);
    g_w[s][g_cnt[s]]   = VW'(w);
    g_cnt[s]++;
  endtask

  task automatic rand_graph();
    clear_graph();
    for (int i = 0; i < N; i++) begin
      int c;
      c = $urandom_range(0, 4);
      for (int j = 0; j < c; j++)
        add_edge(i, $urandom_range(0, N - 1),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(16'hF000, 16'hFFFF)
                                             : $urandom_range(0, 20));
    end
  endtask

  task automatic do_run(input string tag, input int src, input int tgt, input bit poke);
    int exp_d, d0, v0, cyc;
    logic [N-1:0] exp_v;
    ref_dij(src, tgt, exp_d, exp_v);
    d0 = n_done;
    v0 = n_vpulse;
    start = 1'b1;
    source = IW'(src);
    target = IW'(tgt);
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_pq_reset"}, pq_reset, 1);
    chk({tag, "_init_idx"}, pq_index, src);
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (poke && cyc == 5) begin
        start  = 1'b1;
        source = IW'($urandom_range(0, N - 1));
        target = IW'($urandom_range(0, N - 1));
      end
      @(negedge clock);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_dist"}, target_dist, exp_d);
    chk({tag, "_visited"}, visited_vector, exp_v);
    @(negedge clock);
    chk({tag, "_done_once"}, n_done - d0, 1);
    chk({tag, "_vpulses"}, n_vpulse - v0, $countones(exp_v));
    chk({tag, "_held"}, target_dist, exp_d);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int w0, e0, d0, cyc;
    reset = 1'b1; start = 1'b0; source = '0; target = '0;
    clear_graph();
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tdist", target_dist, 0);
    chk("rst_pq_reset", pq_reset, 0);
    chk("rst_set_en", pq_set_en, 0);
    chk("rst_visited", visited_vector, 0);
    chk("rst_edge_req", edge_req, 0);
    chk("rst_vtrue", visit_vector_true, 0);
    reset = 1'b0;
    @(negedge clock);

    // Chain 0->1->2
    add_edge(0, 1, 3); add_edge(1, 2, 4);
    do_run("chain", 0, 2, 0);
    chk("chain_const", target_dist, 7);
    chk("chain_vis_const", visited_vector, 16'h0003);

    // Diamond: node 2 written 5 then 2
    clear_graph();
    add_edge(0, 1, 1); add_edge(0, 2, 5); add_edge(1, 2, 1);
    w0 = wlog.size();
    do_run("diamond", 0, 2, 0);
    chk("diamond_const", target_dist, 2);
    chk("diamond_nwr", wlog.size() - w0, 3);
    if (wlog.size() >= w0 + 3) begin
      chk("diamond_wr0", wlog[w0],     {4'd1, 16'd1});
      chk("diamond_wr1", wlog[w0 + 1], {4'd2, 16'd5});
      chk("diamond_wr2", wlog[w0 + 2], {4'd2, 16'd2});
    end

    // Unreachable target
    clear_graph();
    add_edge(0, 1, 2); add_edge(1, 2, 2);
    do_run("unreach", 0, 3, 0);
    chk("unreach_const", target_dist, 16'hFFFF);

    // Saturation: du=FFF0 plus 0020 must not write
    clear_graph();
    add_edge(0, 1, 16'hFFF0); add_edge(1, 2, 16'h0020);
    w0 = wlog.size();
    do_run("sat", 0, 2, 0);
    chk("sat_const", target_dist, 16'hFFFF);
    chk("sat_nwr", wlog.size() - w0, 1);

    // source == target
    clear_graph();
    add_edge(5, 6, 1); add_edge(5, 5, 0);
    e0 = n_ereq;
    do_run("same", 5, 5, 0);
    chk("same_const", target_dist, 0);
    chk("same_no_req", n_ereq - e0, 0);

    // Self-loop and zero weight
    clear_graph();
    add_edge(0, 0, 0); add_edge(0, 1, 0); add_edge(1, 0, 0); add_edge(1, 4, 9);
    do_run("zero_w", 0, 4, 0);
    chk("zero_w_const", target_dist, 9);

    // Reset while relaxing
    clear_graph();
    add_edge(0, 1, 3); add_edge(1, 2, 4);
    d0 = n_done;
    start = 1'b1; source = '0; target = 4'd2;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!pq_set_en && cyc < 200) begin @(negedge clock); cyc++; end
    chk("rr_reached_relax", pq_set_en, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("rr_set_en", pq_set_en, 0);
    chk("rr_busy", busy, 0);
    chk("rr_visited", visited_vector, 0);
    chk("rr_edge_req", edge_req, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rr_no_done", n_done - d0, 0);
    do_run("rr_rerun", 0, 2, 0);

    // Randomized graphs, some with start pulses mid-run
    for (int r = 0; r < 24; r++) begin
      rand_graph();
      do_run("rand", $urandom_range(0, N - 1), $urandom_range(0, N - 1), (r % 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
